// File: rtl/seg_disp_sched.sv
// Round-robin scheduler sharing one 2-digit seven_seg display among NUM_SRC byte producers.
// Each source holding data is loaded for DWELL_CYCLES cycles; all display outputs are registered.
module seg_disp_sched #(
  parameter  int NUM_SRC      = 4,
  parameter  int DWELL_CYCLES = 1024,
  localparam int SW           = $clog2(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_clr,
  output logic                 disp_valid,
  output logic [7:0]           disp_val,
  output logic                 disp_off,
  output logic [SW-1:0]        cur_src
);

  localparam int            CW      = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] CNT_TOP = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [7:0]          hold     [NUM_SRC];
  logic [7:0]          hold_nxt [NUM_SRC];
  logic [NUM_SRC-1:0]  has_data, has_nxt;

  logic                valid_nxt;
  logic                off_nxt;
  logic [7:0]          val_nxt;
  logic [SW-1:0]       cur_nxt;

  logic [SW-1:0]       rr_sel;
  logic                rr_found;
  logic [SW-1:0]       low_sel;
  logic                any_elig;
  logic [SW:0]         rr_idx;
  logic                load_req;
  logic [SW-1:0]       load_sel;

  // Decisions use the post-write view so a write/clear takes effect in the very next cycle.
  always_comb begin
    hold_nxt = hold;
    has_nxt  = has_data;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i]) begin
        hold_nxt[i] = src_data[8*i +: 8];
        has_nxt[i]  = 1'b1;
      end else if (src_clr[i]) begin
        has_nxt[i]  = 1'b0;
      end
    end
  end

  // Round-robin search starts after cur_src and visits cur_src itself last.
  always_comb begin
    rr_sel   = cur_src;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      rr_idx = {1'b0, cur_src} + (SW+1)'(k);
      if (rr_idx >= (SW+1)'(NUM_SRC)) begin
        rr_idx = rr_idx - (SW+1)'(NUM_SRC);
      end
      if (!rr_found && has_nxt[rr_idx[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx[SW-1:0];
      end
    end
  end

  always_comb begin
    low_sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (has_nxt[i]) begin
        low_sel = SW'(i);
      end
    end
    any_elig = |has_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    valid_nxt = 1'b0;
    val_nxt   = disp_val;
    cur_nxt   = cur_src;
    off_nxt   = disp_off;
    load_req  = 1'b0;
    load_sel  = cur_src;

    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      off_nxt   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          off_nxt = 1'b1;
          if (any_elig) begin
            load_req = 1'b1;
            load_sel = low_sel;
          end
        end
        LOAD, SHOW: begin
          if (!has_nxt[cur_src]) begin
            if (rr_found) begin
              load_req = 1'b1;
              load_sel = rr_sel;
            end else begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
              off_nxt   = 1'b1;
            end
          end else if (cnt == '0) begin
            load_req = 1'b1;
            load_sel = rr_sel;
          end else begin
            // A fresh byte for the shown source is pushed out without touching the dwell timer.
            state_nxt = SHOW;
            cnt_nxt   = cnt - 1'b1;
            if (src_valid[cur_src]) begin
              valid_nxt = 1'b1;
              val_nxt   = hold_nxt[cur_src];
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          off_nxt   = 1'b1;
        end
      endcase
    end

    // Counter counts the LOAD cycle itself, so a source dwells DWELL_CYCLES load-to-load.
    if (load_req) begin
      state_nxt = LOAD;
      cnt_nxt   = CNT_TOP;
      valid_nxt = 1'b1;
      val_nxt   = hold_nxt[load_sel];
      cur_nxt   = load_sel;
      off_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      has_data   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold[i] <= 8'h00;
      end
      disp_valid <= 1'b0;
      disp_val   <= 8'h00;
      disp_off   <= 1'b1;
      cur_src    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      has_data   <= has_nxt;
      hold       <= hold_nxt;
      disp_valid <= valid_nxt;
      disp_val   <= val_nxt;
      disp_off   <= off_nxt;
      cur_src    <= cur_nxt;
    end
  end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Bench for seg_disp_sched: directed scenarios then random traffic, checked every cycle against a rule-level model.
module tb_seg_disp_sched;

  localparam int N  = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [N-1:0]  src_valid = '0;
  logic [8*N-1:0] src_data = '0;
  logic [N-1:0]  src_clr = '0;
  logic          disp_valid;
  logic [7:0]    disp_val;
  logic          disp_off;
  logic [1:0]    cur_src;

  seg_disp_sched #(.NUM_SRC(N), .DWELL_CYCLES(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_clr    (src_clr),
    .disp_valid (disp_valid),
    .disp_val   (disp_val),
    .disp_off   (disp_off),
    .cur_src    (cur_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which bytes are held, whether something is on screen, and how long it has been up.
  logic [7:0]   m_hold [N];
  logic [N-1:0] m_has;
  bit           m_on;
  int           m_cur;
  int           m_age;
  bit           m_loaded;
  logic         e_valid;
  logic [7:0]   e_val;
  logic         e_off;
  logic [1:0]   e_cur;

  function automatic int first_from(input int start);
    for (int k = 0; k < N; k++) begin
      int s;
      s = (start + k) % N;
      if (m_has[s]) return s;
    end
    return -1;
  endfunction

  task automatic show_src(input int s);
    e_valid  = 1'b1;
    e_val    = m_hold[s];
    e_cur    = 2'(s);
    e_off    = 1'b0;
    m_cur    = s;
    m_on     = 1'b1;
    m_age    = 0;
    m_loaded = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_hold[i] = 8'h00;
    m_has    = '0;
    m_on     = 1'b0;
    m_cur    = 0;
    m_age    = 0;
    m_loaded = 1'b0;
    e_valid  = 1'b0;
    e_val    = 8'h00;
    e_off    = 1'b1;
    e_cur    = 2'd0;
  endtask

  task automatic model_step();
    int s;
    m_loaded = 1'b0;
    e_valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (src_valid[i]) begin
        m_hold[i] = src_data[8*i +: 8];
        m_has[i]  = 1'b1;
      end else if (src_clr[i]) begin
        m_has[i]  = 1'b0;
      end
    end
    if (!enable) begin
      m_on  = 1'b0;
      e_off = 1'b1;
    end else if (!m_on) begin
      s = first_from(0);
      if (s >= 0) show_src(s);
    end else if (!m_has[m_cur]) begin
      s = first_from(m_cur + 1);
      if (s >= 0) show_src(s);
      else begin
        m_on  = 1'b0;
        e_off = 1'b1;
      end
    end else if (m_age == DW - 1) begin
      show_src(first_from(m_cur + 1));
    end else begin
      m_age++;
      if (src_valid[m_cur]) begin
        e_valid = 1'b1;
        e_val   = m_hold[m_cur];
      end
    end
  endtask

  task automatic check(input string tag);
    checks++;
    assert (disp_valid === e_valid) else begin
      errors++;
      $error("FAIL %s disp_valid got %0b expected %0b", tag, disp_valid, e_valid);
    end
    checks++;
    assert (disp_val === e_val) else begin
      errors++;
      $error("FAIL %s disp_val got %02h expected %02h", tag, disp_val, e_val);
    end
    checks++;
    assert (disp_off === e_off) else begin
      errors++;
      $error("FAIL %s disp_off got %0b expected %0b", tag, disp_off, e_off);
    end
    checks++;
    assert (cur_src === e_cur) else begin
      errors++;
      $error("FAIL %s cur_src got %0d expected %0d", tag, cur_src, e_cur);
    end
  endtask

  task automatic tick(input logic [N-1:0] v, input logic [8*N-1:0] d,
                      input logic [N-1:0] c, input logic en, input string tag);
    src_valid = v;
    src_data  = d;
    src_clr   = c;
    enable    = en;
    model_step();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic run(input int n, input logic en, input string tag);
    for (int i = 0; i < n; i++) tick('0, '0, '0, en, tag);
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    rst_n = 1'b1;

    run(8, 1'b1, "no_data");

    tick(4'b0001, 32'h0000_003C, '0, 1'b1, "wr_3c");
    run(10, 1'b1, "reload_3c");

    tick(4'b1101, 32'h3322_0011, '0, 1'b1, "wr_three");
    run(14, 1'b1, "rr_order");

    for (int i = 0; i < 20 && !(m_loaded && m_cur == 2); i++) tick('0, '0, '0, 1'b1, "seek_src2");
    checks++;
    assert (disp_valid === 1'b1 && cur_src === 2'd2) else begin
      errors++;
      $error("FAIL seek_src2 valid/cur got %0b/%0d expected 1/2", disp_valid, cur_src);
    end
    tick('0, '0, '0, 1'b1, "show_src2");
    tick(4'b0100, 32'h00AB_0000, '0, 1'b1, "refresh_ab");
    run(8, 1'b1, "after_refresh");

    tick(4'b0010, 32'h0000_5500, 4'b0010, 1'b1, "valid_wins");
    run(12, 1'b1, "with_src1");
    tick('0, '0, 4'(1 << m_cur), 1'b1, "clr_cur");
    run(5, 1'b1, "after_clr_cur");
    tick('0, '0, 4'hF, 1'b1, "clr_all");
    run(4, 1'b1, "idle_after_clr");

    tick(4'b0011, 32'h0000_7766, '0, 1'b1, "wr_again");
    run(2, 1'b1, "show");
    tick('0, '0, '0, 1'b0, "en_drop");
    run(3, 1'b0, "disabled");
    run(6, 1'b1, "reenable");

    for (int i = 0; i < 8 && !m_loaded; i++) tick('0, '0, '0, 1'b1, "seek_load");
    checks++;
    assert (disp_valid === 1'b1) else begin
      errors++;
      $error("FAIL seek_load disp_valid got %0b expected 1", disp_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst");
    #2;
    rst_n = 1'b1;
    run(3, 1'b1, "post_rst");

    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] v;
      logic [N-1:0] c;
      logic         en;
      v  = ($urandom_range(0, 6) == 0) ? 4'($urandom) : 4'b0000;
      c  = ($urandom_range(0, 10) == 0) ? 4'($urandom) : 4'b0000;
      en = ($urandom_range(0, 29) != 0);
      tick(v, $urandom, c, en, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
